// File: rtl/ttl191_sequencer_pkg.sv
// Shared definitions for the 74LS191 sequencer: FSM state encodings and the
// terminal-count value helper.
package ttl191_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_VERIFY = 3'd2;
    localparam state_t ST_COUNT  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // Terminal value zero-extended to 32 bits: all-ones when counting up, zero when counting down.
    function automatic logic [31:0] term_value(input logic dir, input int unsigned width);
        logic [31:0] ones_s;
        ones_s = 32'hFFFF_FFFF >> (32'd32 - width);
        return dir ? 32'd0 : ones_s;
    endfunction

endpackage

// File: rtl/ttl191_terminal_detect.sv
// Flags when the counter readback sits at its terminal value for the given direction.
module ttl191_terminal_detect
    import ttl191_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] cnt_q_i,
    input  logic             dir_i,
    output logic             at_term_o
);

    // Compare in the 32-bit domain so no truncated bits are left dangling.
    always_comb begin
        at_term_o = (32'(cnt_q_i) == term_value(dir_i, WIDTH));
    end

endmodule

// File: rtl/ttl191_sequencer.sv
// Load / verify / count / done controller wrapped around an external 74LS191
// up/down counter, with one-shot and auto-reload operation.
module ttl191_sequencer
    import ttl191_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             START,
    input  logic             ABORT,
    input  logic             MODE,
    input  logic             DIR,
    input  logic [WIDTH-1:0] PRESET,
    output logic [WIDTH-1:0] CNT_D,
    output logic             CNT_LOAD_n,
    output logic             CNT_CTEN_n,
    output logic             CNT_DOWN_UP_n,
    input  logic [WIDTH-1:0] CNT_Q,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAULT,
    output logic [7:0]       PERIODS
);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] d_q,       d_d;
    logic             dir_q,     dir_d;
    logic [7:0]       periods_q, periods_d;
    logic             done_q,    done_d;
    logic             fault_q,   fault_d;
    logic             at_term_s;

    ttl191_terminal_detect #(.WIDTH(WIDTH)) u_term (
        .cnt_q_i   (CNT_Q),
        .dir_i     (dir_q),
        .at_term_o (at_term_s)
    );

    // Next-state logic; ABORT overrides everything, including a pending START.
    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        dir_d     = dir_q;
        periods_d = periods_q;
        done_d    = 1'b0;
        fault_d   = 1'b0;
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_d   = ST_LOAD;
                        d_d       = PRESET;
                        dir_d     = DIR;
                        periods_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (CNT_Q != d_q) begin
                        state_d = ST_IDLE;
                        fault_d = 1'b1;
                    end else if (at_term_s) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        periods_d = periods_q + 8'd1;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (at_term_s) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        periods_d = periods_q + 8'd1;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
                ST_DONE: begin
                    // Reload reuses the preset and direction latched at START.
                    if (MODE) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= ST_IDLE;
            d_q       <= '0;
            dir_q     <= 1'b0;
            periods_q <= 8'd0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            dir_q     <= dir_d;
            periods_q <= periods_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
        end
    end

    // Count enable follows CNT_Q directly so the 191 freezes on the terminal value instead of wrapping.
    always_comb begin
        if (state_q == ST_COUNT) begin
            CNT_CTEN_n = at_term_s;
        end else begin
            CNT_CTEN_n = 1'b1;
        end
    end

    assign CNT_LOAD_n    = (state_q != ST_LOAD);
    assign CNT_D         = d_q;
    assign CNT_DOWN_UP_n = dir_q;
    assign BUSY          = (state_q != ST_IDLE);
    assign DONE          = done_q;
    assign FAULT         = fault_q;
    assign PERIODS       = periods_q;

endmodule

// File: tb/tb_ttl191_sequencer.sv
// Self-checking bench: sequencer driving a behavioural 74LS191, with a
// scoreboard of expected DONE/FAULT events keyed by clock edge number.
module tb_ttl191_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, mode, dir;
    logic [3:0] preset;
    logic [3:0] cnt_d;
    logic       load_n, cten_n, down_up_n;
    logic       busy, done, fault;
    logic [7:0] periods;

    logic [3:0] ctr_q     = 4'd0;
    logic       force_en  = 1'b0;
    logic [3:0] force_val = 4'd0;
    logic [3:0] cnt_q_s;
    int         edge_cnt  = 0;
    int         n_tests   = 0;
    int         n_fail    = 0;

    typedef struct {
        logic       is_fault;
        int         edge_n;
        logic [3:0] q;
        logic [7:0] periods;
    } exp_t;
    exp_t sb_q[$];

    always #50 clk = ~clk;

    assign cnt_q_s = force_en ? force_val : ctr_q;

    ttl191_sequencer #(.WIDTH(4)) dut (
        .CLK           (clk),
        .RESET_n       (rst_n),
        .START         (start),
        .ABORT         (abort),
        .MODE          (mode),
        .DIR           (dir),
        .PRESET        (preset),
        .CNT_D         (cnt_d),
        .CNT_LOAD_n    (load_n),
        .CNT_CTEN_n    (cten_n),
        .CNT_DOWN_UP_n (down_up_n),
        .CNT_Q         (cnt_q_s),
        .BUSY          (busy),
        .DONE          (done),
        .FAULT         (fault),
        .PERIODS       (periods)
    );

    // Behavioural 74LS191: parallel load, count enable, up/down, no reset.
    always @(posedge clk) begin
        if (load_n === 1'b0)
            ctr_q <= cnt_d;
        else if (cten_n === 1'b0)
            ctr_q <= down_up_n ? ctr_q - 4'd1 : ctr_q + 4'd1;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Scoreboard: every DONE/FAULT pulse must match the next expected event.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (done === 1'b1 || fault === 1'b1)) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_event", {30'd0, done, fault}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("ev_kind",    {31'd0, fault}, {31'd0, e.is_fault});
                check_eq("ev_edge",    edge_cnt, e.edge_n);
                check_eq("ev_q",       {28'd0, cnt_q_s}, {28'd0, e.q});
                check_eq("ev_periods", {24'd0, periods}, {24'd0, e.periods});
                check_eq("ev_exclusive", {31'd0, done & fault}, 32'd0);
            end
        end
    end

    task automatic drive_start(input logic [3:0] p, input logic d, input logic m,
                               input int n_done, input logic exp_fault,
                               input logic [3:0] fq, output int e0);
        int   n;
        exp_t e;
        @(negedge clk);
        preset = p;
        dir    = d;
        mode   = m;
        start  = 1'b1;
        e0     = edge_cnt + 1;
        n      = d ? int'(p) : 15 - int'(p);
        if (exp_fault) begin
            e.is_fault = 1'b1;
            e.edge_n   = e0 + 2;
            e.q        = fq;
            e.periods  = 8'd0;
            sb_q.push_back(e);
        end else begin
            for (int k = 0; k < n_done; k++) begin
                e.is_fault = 1'b0;
                e.edge_n   = (n == 0) ? e0 + 2 : e0 + n + 3 + k * (n + 4);
                e.q        = d ? 4'd0 : 4'd15;
                e.periods  = 8'(k + 1);
                sb_q.push_back(e);
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && busy; i++) @(negedge clk);
        check_eq("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int         e0;
        logic [3:0] held_q;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        mode   = 1'b0;
        dir    = 1'b0;
        preset = 4'd0;
        #10;
        check_eq("rst_busy",    {31'd0, busy},      32'd0);
        check_eq("rst_done",    {31'd0, done},      32'd0);
        check_eq("rst_fault",   {31'd0, fault},     32'd0);
        check_eq("rst_periods", {24'd0, periods},   32'd0);
        check_eq("rst_load_n",  {31'd0, load_n},    32'd1);
        check_eq("rst_cten_n",  {31'd0, cten_n},    32'd1);
        check_eq("rst_dir",     {31'd0, down_up_n}, 32'd0);
        check_eq("rst_d",       {28'd0, cnt_d},     32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // One-shot down from 5: DONE after edge 8, holds at 0.
        drive_start(4'd5, 1'b1, 1'b0, 1, 1'b0, 4'd0, e0);
        for (int k = 2; k <= 10; k++) begin
            wait_until(e0 + k);
            check_eq("dn_q", {28'd0, ctr_q}, (k < 7) ? 32'(7 - k) : 32'd0);
            if (k == 9) check_eq("dn_busy", {31'd0, busy}, 32'd0);
        end

        // One-shot up from 13: DONE after edge 5, holds at 15 without wrapping.
        drive_start(4'd13, 1'b0, 1'b0, 1, 1'b0, 4'd0, e0);
        for (int k = 2; k <= 8; k++) begin
            wait_until(e0 + k);
            check_eq("up_q", {28'd0, ctr_q}, (k <= 4) ? 32'(11 + k) : 32'd15);
        end
        wait_idle();

        // Periodic down from 2: DONE every 6 cycles, then ABORT keeps PERIODS.
        drive_start(4'd2, 1'b1, 1'b1, 3, 1'b0, 4'd0, e0);
        wait_until(e0 + 18);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy",    {31'd0, busy},    32'd0);
        check_eq("abort_periods", {24'd0, periods}, 32'd3);
        repeat (10) @(negedge clk);
        check_eq("abort_hold",    {24'd0, periods}, 32'd3);

        // Preset already at terminal: DONE after edge 2.
        mode = 1'b0;
        drive_start(4'd0, 1'b1, 1'b0, 1, 1'b0, 4'd0, e0);
        wait_idle();
        check_eq("zero_q", {28'd0, ctr_q}, 32'd0);

        // START/PRESET/DIR changes during COUNT are ignored.
        drive_start(4'd5, 1'b1, 1'b0, 1, 1'b0, 4'd0, e0);
        wait_until(e0 + 4);
        start  = 1'b1;
        preset = 4'd1;
        dir    = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        wait_idle();
        check_eq("ign_q",       {28'd0, ctr_q},   32'd0);
        check_eq("ign_d",       {28'd0, cnt_d},   32'd5);
        check_eq("ign_periods", {24'd0, periods}, 32'd1);

        // Readback mismatch: FAULT after edge 2, back to IDLE.
        force_en  = 1'b1;
        force_val = 4'd9;
        drive_start(4'd8, 1'b0, 1'b0, 0, 1'b1, 4'd9, e0);
        wait_until(e0 + 3);
        check_eq("flt_busy",  {31'd0, busy},  32'd0);
        check_eq("flt_pulse", {31'd0, fault}, 32'd0);
        force_en = 1'b0;
        start    = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        abort    = 1'b0;
        check_eq("sa_busy",   {31'd0, busy},   32'd0);
        check_eq("sa_load_n", {31'd0, load_n}, 32'd1);

        // Asynchronous reset in the middle of the second periodic COUNT.
        drive_start(4'd2, 1'b1, 1'b1, 1, 1'b0, 4'd0, e0);
        wait_until(e0 + 8);
        check_eq("pre_rst_cten", {31'd0, cten_n},  32'd0);
        check_eq("pre_rst_per",  {24'd0, periods}, 32'd1);
        held_q = ctr_q;
        #5;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_cten",    {31'd0, cten_n},  32'd1);
        check_eq("mid_rst_load",    {31'd0, load_n},  32'd1);
        check_eq("mid_rst_busy",    {31'd0, busy},    32'd0);
        check_eq("mid_rst_periods", {24'd0, periods}, 32'd0);
        @(negedge clk);
        check_eq("mid_rst_q", {28'd0, ctr_q}, {28'd0, held_q});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
